// File: rtl/mem_access_unit.sv
// MEM-stage data-memory initiator: extended loads, single-cycle SW, two-cycle SB/SH
// read-modify-write, illegal-access detection and access counters.
module mem_access_unit #(
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned MEM_BYTES = 512
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req_valid,
    input  logic             i_req_we,
    input  logic [2:0]       i_req_type,
    input  logic [31:0]      i_req_addr,
    input  logic [31:0]      i_req_wdata,
    input  logic [31:0]      i_req_pc,
    output logic [31:0]      o_load_data,
    output logic             o_stall,
    output logic             o_misalign_err,
    output logic [31:0]      o_err_addr,
    output logic [CNT_W-1:0] o_ld_cnt,
    output logic [CNT_W-1:0] o_st_cnt,
    output logic [CNT_W-1:0] o_rmw_cnt,
    output logic             o_dm_we,
    output logic [31:0]      o_dm_addr,
    output logic [31:0]      o_dm_wdata,
    output logic [31:0]      o_dm_pc,
    input  logic [31:0]      i_dm_rdata
);

    typedef enum logic {StIdle, StRmwWr} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [31:0]      r_rmw_addr;
    logic [31:0]      r_rmw_data;
    logic [31:0]      r_rmw_pc;
    logic             r_err;
    logic [31:0]      r_err_addr;
    logic [CNT_W-1:0] r_ld_cnt;
    logic [CNT_W-1:0] r_st_cnt;
    logic [CNT_W-1:0] r_rmw_cnt;

    logic             w_type_ok;
    logic             w_align_ok;
    logic             w_in_range;
    logic             w_idle_req;
    logic             w_accept;
    logic             w_reject;
    logic             w_is_sw;
    logic             w_is_rmw;
    logic [31:0]      w_aligned;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_merged;

    always_comb begin
        w_type_ok  = 1'b0;
        w_align_ok = 1'b1;
        case (i_req_type)
            3'b000: w_type_ok = 1'b1;
            3'b001: begin
                w_type_ok  = 1'b1;
                w_align_ok = ~i_req_addr[0];
            end
            3'b010: begin
                w_type_ok  = 1'b1;
                w_align_ok = (i_req_addr[1:0] == 2'b00);
            end
            3'b100: w_type_ok = ~i_req_we;
            3'b101: begin
                w_type_ok  = ~i_req_we;
                w_align_ok = ~i_req_addr[0];
            end
            default: w_type_ok = 1'b0;
        endcase
    end

    assign w_in_range = (i_req_addr < 32'(MEM_BYTES));
    assign w_idle_req = (r_state == StIdle) && i_req_valid;
    assign w_accept   = w_idle_req && w_type_ok && w_align_ok && w_in_range;
    assign w_reject   = w_idle_req && !(w_type_ok && w_align_ok && w_in_range);
    assign w_is_sw    = w_accept && i_req_we && (i_req_type == 3'b010);
    assign w_is_rmw   = w_accept && i_req_we && (i_req_type != 3'b010);
    assign w_aligned  = {i_req_addr[31:2], 2'b00};
    assign w_byte     = i_dm_rdata[8*i_req_addr[1:0] +: 8];
    assign w_half     = i_dm_rdata[16*i_req_addr[1] +: 16];

    // Target lane of the read word replaced by the store data.
    always_comb begin
        w_merged = i_dm_rdata;
        if (i_req_type[0]) begin
            w_merged[16*i_req_addr[1] +: 16] = i_req_wdata[15:0];
        end else begin
            w_merged[8*i_req_addr[1:0] +: 8] = i_req_wdata[7:0];
        end
    end

    always_comb begin
        w_state_next = r_state;
        o_dm_we      = 1'b0;
        o_dm_addr    = w_aligned;
        o_dm_wdata   = i_req_wdata;
        o_dm_pc      = i_req_pc;
        o_stall      = 1'b0;
        o_load_data  = 32'h0;
        case (r_state)
            StRmwWr: begin
                // Reset in this cycle cancels the pending write.
                o_dm_we      = ~i_rst;
                o_dm_addr    = r_rmw_addr;
                o_dm_wdata   = r_rmw_data;
                o_dm_pc      = r_rmw_pc;
                w_state_next = StIdle;
            end
            default: begin
                if (w_is_sw) begin
                    o_dm_we = 1'b1;
                end else if (w_is_rmw) begin
                    o_stall      = 1'b1;
                    w_state_next = StRmwWr;
                end else if (w_accept) begin
                    case (i_req_type)
                        3'b000:  o_load_data = {{24{w_byte[7]}}, w_byte};
                        3'b001:  o_load_data = {{16{w_half[15]}}, w_half};
                        3'b100:  o_load_data = {24'h0, w_byte};
                        3'b101:  o_load_data = {16'h0, w_half};
                        default: o_load_data = i_dm_rdata;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= StIdle;
            r_rmw_addr <= 32'h0;
            r_rmw_data <= 32'h0;
            r_rmw_pc   <= 32'h0;
            r_err      <= 1'b0;
            r_err_addr <= 32'h0;
            r_ld_cnt   <= '0;
            r_st_cnt   <= '0;
            r_rmw_cnt  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_reject) begin
                r_err <= 1'b1;
                if (!r_err) begin
                    r_err_addr <= i_req_addr;
                end
            end
            if (w_accept && !i_req_we) begin
                r_ld_cnt <= r_ld_cnt + CNT_W'(1);
            end
            if (w_is_rmw) begin
                r_rmw_addr <= w_aligned;
                r_rmw_data <= w_merged;
                r_rmw_pc   <= i_req_pc;
            end
            if (r_state == StRmwWr) begin
                r_st_cnt  <= r_st_cnt + CNT_W'(1);
                r_rmw_cnt <= r_rmw_cnt + CNT_W'(1);
            end else if (w_is_sw) begin
                r_st_cnt <= r_st_cnt + CNT_W'(1);
            end
        end
    end

    assign o_misalign_err = r_err;
    assign o_err_addr     = r_err_addr;
    assign o_ld_cnt       = r_ld_cnt;
    assign o_st_cnt       = r_st_cnt;
    assign o_rmw_cnt      = r_rmw_cnt;

endmodule
